serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder controller that time-shares one full_adder cell across WIDTH bit positions. It runs one bit per clock, LSB first. It captures operands on a start pulse, steps the cell with a registered carry and asserts a one-cycle done with the WIDTH-bit sum and carry-out. It is the sequencing layer above the combinational full_adder datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured at start
b  input  WIDTH  operand B, captured at start
cin  input  1  initial carry-in, captured at start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result; holds last completed value
cout  output  1  final carry-out; holds last completed value

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and bit counter cleared.
- States: IDLE, RUN. There is no separate DONE state; done is a registered pulse.
- IDLE, start=1 at edge E0:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0
  - state->RUN, busy<=1
- RUN, each edge:
  - the full_adder is driven with A=a_sh[0], B=b_sh[0], Cin=carry
  - a_sh and b_sh shift right by 1
  - S shifts into s_sh at the MSB
  - carry<=C, cnt<=cnt+1
- Edge E0+WIDTH processes bit WIDTH-1. On that edge:
  - sum<= final s_sh including this S, cout<=C
  - done<=1 for exactly one cycle, busy<=0, state->IDLE
- Latency: done is high in the cycle after edge E0+WIDTH. busy is high for exactly WIDTH cycles.
- start while busy=1 is ignored: no queueing, no effect on operands.
- start=1 in the cycle done=1 is accepted, because state is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles with no gap cycle lost.
- Input changes on a/b/cin after capture have no effect on the running addition.
- sum and cout change only on a completion edge or reset. Between completions they hold.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- Counter is ceil(log2(WIDTH+1)) bits. cnt==WIDTH-1 is the terminal condition, and it never wraps in RUN.
- WIDTH=1 is legal: RUN lasts one cycle.
- Reset mid-RUN aborts the addition:
  - no done pulse
  - sum/cout return to 0
  - the next start after reset release behaves normally

Decomposition:
- Shared include/package holds:
  - state encoding localparams: ST_IDLE=1'b0, ST_RUN=1'b1
  - a CNT_W function/localparam derived from WIDTH
- Sub-module: instantiate the existing full_adder (ports A, B, Cin, S, C) exactly once. No other arithmetic is permitted in the controller.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse at edge 0 -> busy high 8 cycles; done pulse after edge 8; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start held high during RUN with new a=0x11, b=0x22 -> ignored; result still the first operands. Next start asserted in the done cycle with a=0x01, b=0x02 -> accepted; second done exactly 9 cycles after first; sum=0x03.
- Change a/b mid-RUN -> result matches values captured at start.
- rst_n pulsed low at cycle 4 of RUN -> busy=0, sum=0, cout=0 immediately; no done pulse; subsequent 0x10+0x20 gives 0x30.
- WIDTH=3 instance, exhaustive loop over all {a,b,cin} (128 cases) -> {cout,sum} == a+b+cin every time. WIDTH=1 instance covers all 8 input combinations, matching a full_adder truth table.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the bit-counter width helper.
// No logic; imported by the controller.
package serial_adder_ctrl_pkg;

  // Two-state sequencer: waiting for start, or stepping bits.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter must hold 0..WIDTH-1, sized as ceil(log2(WIDTH+1)), at least 1 bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell time-shared by the serial controller.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic C
);

  logic w_p;

  assign w_p = A ^ B;
  assign S   = w_p ^ Cin;
  assign C   = (A & B) | (Cin & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell stepped LSB first, one bit per clock.
// Latency: done pulses in the cycle after the WIDTH-th RUN edge; WIDTH+1 cycles per result.
// Backpressure: none; start is sampled only while idle, ignored while busy (no queueing).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_s_next;

  // The single arithmetic cell: current LSBs plus the registered carry.
  full_adder u_fa (
    .A   (r_a_sh[0]),
    .B   (r_b_sh[0]),
    .Cin (r_carry),
    .S   (w_fa_s),
    .C   (w_fa_c)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // Partial sum register only needs WIDTH-1 bits: the final bit is
  // taken straight from the cell on the completion edge.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_next = w_fa_s;
    end else begin : g_wn
      logic [WIDTH-2:0] r_s_sh;

      assign w_s_next = {w_fa_s, r_s_sh};

      // Sum bits enter at the MSB and drift right as later bits arrive.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s_sh <= '0;
        end else if (w_load) begin
          r_s_sh <= '0;
        end else if (w_step) begin
          r_s_sh <= w_s_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and step decode; completion returns straight to IDLE so a
  // start in the done cycle is accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand shifters, carry and bit counter: loaded on start, stepped in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_fa_c;
      r_cnt   <= w_last ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  // Result registers update only on the completion edge; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_sum  <= w_s_next;
        r_cout <= w_fa_c;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus exhaustive
// WIDTH=3 and WIDTH=1 instances. Inputs driven and outputs sampled 1ns
// after the rising edge.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       cin3 = 1'b0;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step the WIDTH=8 instance until done, bounded; counts busy cycles seen.
  task automatic wait_done8(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done8 && n < 40) begin
      if (busy8) nbusy++;
      tick();
      n++;
    end
  endtask

  // Launch one WIDTH=8 addition: start high across one edge, then released.
  task automatic launch8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  initial begin : stim
    int n, nb, ndone;
    logic [6:0] v;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_sum",  32'(sum8),  0);
    chk("rst_cout", 32'(cout8), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 0x5A + 0x3C: busy for 8 cycles, done after edge 8
    launch8(8'h5A, 8'h3C, 1'b0);
    chk("t1_busy_after_start", 32'(busy8), 1);
    wait_done8(n, nb);
    chk("t1_latency", 32'(n), 8);
    chk("t1_busy_cycles", 32'(nb), 8);
    chk("t1_busy_in_done", 32'(busy8), 0);
    chk("t1_sum", 32'(sum8), 32'h96);
    chk("t1_cout", 32'(cout8), 0);
    tick();
    chk("t1_done_one_cycle", 32'(done8), 0);
    chk("t1_sum_hold", 32'(sum8), 32'h96);

    // 0xFF + 0x01 carries all the way out
    launch8(8'hFF, 8'h01, 1'b0);
    tick();
    chk("t2_sum_hold_during_run", 32'(sum8), 32'h96);
    wait_done8(n, nb);
    chk("t2_sum", 32'(sum8), 32'h00);
    chk("t2_cout", 32'(cout8), 1);
    tick();

    // 0xFF + 0xFF + 1
    launch8(8'hFF, 8'hFF, 1'b1);
    wait_done8(n, nb);
    chk("t3_sum", 32'(sum8), 32'hFF);
    chk("t3_cout", 32'(cout8), 1);
    tick();

    // start held during RUN with new operands is ignored; start in done cycle accepted
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h11; b8 = 8'h22;
    wait_done8(n, nb);
    chk("t4_ignore_latency", 32'(n), 8);
    chk("t4_ignore_sum", 32'(sum8), 32'h96);
    chk("t4_ignore_cout", 32'(cout8), 0);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    chk("t4_accept_busy", 32'(busy8), 1);
    wait_done8(n, nb);
    chk("t4_back_to_back_gap", 32'(n + 1), 9);
    chk("t4_b2b_sum", 32'(sum8), 32'h03);
    chk("t4_b2b_cout", 32'(cout8), 0);
    tick();

    // operands changed mid-RUN: result from captured values 0x0F+0x01+1
    launch8(8'h0F, 8'h01, 1'b1);
    tick(); tick();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    wait_done8(n, nb);
    chk("t5_sum", 32'(sum8), 32'h11);
    chk("t5_cout", 32'(cout8), 0);
    tick();

    // reset at RUN cycle 4 aborts: outputs cleared at once, no done pulse
    launch8(8'hFF, 8'h01, 1'b0);
    tick(); tick(); tick();
    chk("t6_busy_before_rst", 32'(busy8), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy8), 0);
    chk("t6_rst_sum", 32'(sum8), 0);
    chk("t6_rst_cout", 32'(cout8), 0);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("t6_no_done_after_abort", 32'(ndone), 0);
    chk("t6_idle_after_abort", 32'(busy8), 0);
    launch8(8'h10, 8'h20, 1'b0);
    wait_done8(n, nb);
    chk("t6_post_rst_latency", 32'(n), 8);
    chk("t6_post_rst_sum", 32'(sum8), 32'h30);
    chk("t6_post_rst_cout", 32'(cout8), 0);
    tick();

    // WIDTH=3 exhaustive
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      a3 = v[6:4]; b3 = v[3:1]; cin3 = v[0]; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      n = 0;
      while (!done3 && n < 10) begin
        tick();
        n++;
      end
      chk("w3_latency", 32'(n), 3);
      chk("w3_result", 32'({cout3, sum3}), 32'(a3) + 32'(b3) + 32'(cin3));
      tick();
    end

    // WIDTH=1 full-adder truth table: index = {a,b,cin}, expected {cout,sum}
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_tt [8];
      exp_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      v = 7'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin
        tick();
        n++;
      end
      chk("w1_latency", 32'(n), 1);
      chk("w1_result", 32'({cout1, sum1}), 32'(exp_tt[i]));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
